// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings, control-word layout and FSM state type for the multicycle
// control unit.
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_HALT  = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_BGT   = 4'b0100;
    localparam logic [3:0] OP_BLT   = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_JMP   = 4'b0111;
    localparam logic [3:0] OP_LBU   = 4'b1010;
    localparam logic [3:0] OP_SB    = 4'b1011;
    localparam logic [3:0] OP_LW    = 4'b1100;
    localparam logic [3:0] OP_SW    = 4'b1101;
    localparam logic [3:0] OP_TYPEA = 4'b1111;

    localparam logic [1:0] ALU_CTRL_TYPEA = 2'b00;
    localparam logic [1:0] ALU_CTRL_LOGIC = 2'b01;
    localparam logic [1:0] ALU_CTRL_ADDR  = 2'b10;

    localparam logic [1:0] REG_WR_NONE   = 2'b00;
    localparam logic [1:0] REG_WR_SINGLE = 2'b01;
    localparam logic [1:0] REG_WR_PAIR   = 2'b11;

    localparam logic [1:0] JB_NONE   = 2'b00;
    localparam logic [1:0] JB_BRANCH = 2'b01;
    localparam logic [1:0] JB_JUMP   = 2'b11;

    typedef struct packed {
        logic       alu_b_type;
        logic       alu_src;
        logic       sign_change;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic [1:0] alu_control;
        logic [1:0] reg_write;
        logic [1:0] jump_branch;
    } ctrl_word_t;

    typedef enum logic [1:0] {StRun, StMdBusy, StBubble, StHalted} state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Instruction handshake in, registered datapath control word out.
interface multicycle_ctrl_fsm_if #(
    parameter int unsigned OPCODE_W = 4
);
    logic                instr_valid;
    logic                instr_ready;
    logic [OPCODE_W-1:0] opcode;
    logic                multi_div;
    logic                ctrl_valid;
    logic                alu_b_type;
    logic                alu_src;
    logic                sign_change;
    logic                mem_read;
    logic                mem_to_reg;
    logic                mem_write;
    logic [1:0]          alu_control;
    logic [1:0]          reg_write;
    logic [1:0]          jump_branch;
    logic                stall;
    logic                halted;
    logic                illegal_op;

    modport master (
        output instr_valid, opcode, multi_div,
        input  instr_ready, ctrl_valid, alu_b_type, alu_src, sign_change, mem_read,
               mem_to_reg, mem_write, alu_control, reg_write, jump_branch, stall, halted,
               illegal_op
    );

    modport slave (
        input  instr_valid, opcode, multi_div,
        output instr_ready, ctrl_valid, alu_b_type, alu_src, sign_change, mem_read,
               mem_to_reg, mem_write, alu_control, reg_write, jump_branch, stall, halted,
               illegal_op
    );
endinterface

// File: rtl/ctrl_decode.sv
// Pure combinational opcode decoder; undefined opcodes yield an all-zero word
// with illegal set.
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                multi_div,
    output ctrl_word_t          word,
    output logic                illegal,
    output logic                halt
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        halt    = 1'b0;
        if ((opcode >> 4) != '0) begin
            illegal = 1'b1;
        end else begin
            case (opcode[3:0])
                OP_TYPEA: begin
                    word.alu_control = ALU_CTRL_TYPEA;
                    word.reg_write   = multi_div ? REG_WR_PAIR : REG_WR_SINGLE;
                end
                OP_ANDI, OP_ORI: begin
                    word.alu_src     = 1'b1;
                    word.alu_control = ALU_CTRL_LOGIC;
                    word.reg_write   = REG_WR_SINGLE;
                end
                OP_LW, OP_LBU: begin
                    word.alu_b_type  = 1'b1;
                    word.alu_src     = 1'b1;
                    word.alu_control = ALU_CTRL_ADDR;
                    word.mem_read    = 1'b1;
                    word.mem_to_reg  = 1'b1;
                    word.sign_change = (opcode[3:0] == OP_LBU);
                end
                OP_SB, OP_SW: begin
                    word.alu_b_type  = 1'b1;
                    word.alu_src     = 1'b1;
                    word.alu_control = ALU_CTRL_ADDR;
                    word.mem_write   = 1'b1;
                end
                OP_BGT, OP_BLT, OP_BEQ: word.jump_branch = JB_BRANCH;
                OP_JMP:                 word.jump_branch = JB_JUMP;
                OP_HALT:                halt = 1'b1;
                default:                illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Registered, stall-aware control unit: one instruction per handshake, holds issue
// for mult/div latency and branch bubbles, latches HALT until reset.
module multicycle_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W   = 4,
    parameter int unsigned MD_CYCLES  = 4,
    parameter int unsigned BR_BUBBLES = 1
) (
    input logic                  clk,
    input logic                  rst,
    multicycle_ctrl_fsm_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(max_u(MD_CYCLES, BR_BUBBLES) + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_word_t       hold_q, hold_d;
    ctrl_word_t       word_q, word_d;
    logic             valid_q, valid_d;
    logic             illegal_q, illegal_d;

    ctrl_word_t dec_word;
    logic       dec_illegal;
    logic       dec_halt;
    logic       ready;
    logic       fire;

    ctrl_decode #(
        .OPCODE_W(OPCODE_W)
    ) u_decode (
        .opcode   (bus.opcode),
        .multi_div(bus.multi_div),
        .word     (dec_word),
        .illegal  (dec_illegal),
        .halt     (dec_halt)
    );

    assign ready = (state_q == StRun);
    assign fire  = bus.instr_valid & ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        word_d    = '0;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
        unique case (state_q)
            StRun: begin
                if (fire) begin
                    if (dec_halt) begin
                        valid_d = 1'b1;
                        state_d = StHalted;
                    end else if (dec_word.reg_write == REG_WR_PAIR && MD_CYCLES > 1) begin
                        hold_d  = dec_word;
                        cnt_d   = CNT_W'(MD_CYCLES - 1);
                        state_d = StMdBusy;
                    end else begin
                        valid_d   = 1'b1;
                        word_d    = dec_word;
                        illegal_d = dec_illegal;
                        if (dec_word.jump_branch != JB_NONE && BR_BUBBLES > 0) begin
                            cnt_d   = CNT_W'(BR_BUBBLES - 1);
                            state_d = StBubble;
                        end
                    end
                end
            end
            StMdBusy: begin
                // Issue one cycle before the count expires so the pulse lands in the
                // last busy cycle, giving acceptance-to-valid of exactly MD_CYCLES.
                if (cnt_q == CNT_W'(1)) begin
                    valid_d = 1'b1;
                    word_d  = hold_q;
                end
                if (cnt_q == '0) state_d = StRun;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            StBubble: begin
                if (cnt_q == '0) state_d = StRun;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            StHalted: ;
            default:  state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRun;
            cnt_q     <= '0;
            hold_q    <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.instr_ready = ready;
    assign bus.halted      = (state_q == StHalted);
    assign bus.stall       = ~ready & (state_q != StHalted);
    assign bus.ctrl_valid  = valid_q;
    assign bus.illegal_op  = illegal_q;
    assign bus.alu_b_type  = word_q.alu_b_type;
    assign bus.alu_src     = word_q.alu_src;
    assign bus.sign_change = word_q.sign_change;
    assign bus.mem_read    = word_q.mem_read;
    assign bus.mem_to_reg  = word_q.mem_to_reg;
    assign bus.mem_write   = word_q.mem_write;
    assign bus.alu_control = word_q.alu_control;
    assign bus.reg_write   = word_q.reg_write;
    assign bus.jump_branch = word_q.jump_branch;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed self-checking bench for multicycle_ctrl_fsm (MD_CYCLES=4, BR_BUBBLES=1).
module tb_multicycle_ctrl_fsm;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    // Word packing: {b_type, src, sign, mem_rd, mem_to_reg, mem_wr, alu[1:0], rw[1:0], jb[1:0]}
    localparam logic [11:0] W_ZERO  = 12'h000;
    localparam logic [11:0] W_LW    = 12'hDA0;
    localparam logic [11:0] W_LBU   = 12'hFA0;
    localparam logic [11:0] W_ST    = 12'hC60;
    localparam logic [11:0] W_LOGI  = 12'h414;
    localparam logic [11:0] W_TA    = 12'h004;
    localparam logic [11:0] W_TA_MD = 12'h00C;
    localparam logic [11:0] W_BR    = 12'h001;
    localparam logic [11:0] W_JMP   = 12'h003;

    multicycle_ctrl_fsm_if #(.OPCODE_W(4)) bus ();

    multicycle_ctrl_fsm #(
        .OPCODE_W  (4),
        .MD_CYCLES (4),
        .BR_BUBBLES(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] word_now();
        return {bus.alu_b_type, bus.alu_src, bus.sign_change, bus.mem_read, bus.mem_to_reg,
                bus.mem_write, bus.alu_control, bus.reg_write, bus.jump_branch};
    endfunction

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic md);
        bus.instr_valid = 1'b1;
        bus.opcode      = op;
        bus.multi_div   = md;
        tick();
        bus.instr_valid = 1'b0;
    endtask

    logic [3:0]  tbl_op  [8] = '{4'hC, 4'hA, 4'hB, 4'hD, 4'h1, 4'h2, 4'hF, 4'h9};
    logic [11:0] tbl_exp [8] = '{W_LW, W_LBU, W_ST, W_ST, W_LOGI, W_LOGI, W_TA, W_ZERO};
    logic        tbl_ill [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        bus.instr_valid = 1'b0;
        bus.opcode      = 4'h0;
        bus.multi_div   = 1'b0;
        rst             = 1'b1;
        repeat (3) tick();
        check("rst_ready", bus.instr_ready, 1);
        check("rst_valid", bus.ctrl_valid, 0);
        check("rst_word", word_now(), W_ZERO);
        check("rst_stall_halt", {bus.stall, bus.halted, bus.illegal_op}, 0);
        rst = 1'b0;
        tick();

        // single-cycle decodes, including illegal 1001
        for (int i = 0; i < 8; i++) begin
            send(tbl_op[i], 1'b0);
            check($sformatf("dec_valid_%h", tbl_op[i]), bus.ctrl_valid, 1);
            check($sformatf("dec_word_%h", tbl_op[i]), word_now(), tbl_exp[i]);
            check($sformatf("dec_ill_%h", tbl_op[i]), bus.illegal_op, tbl_ill[i]);
            check($sformatf("dec_ready_%h", tbl_op[i]), bus.instr_ready, 1);
        end
        tick();
        check("idle_valid", bus.ctrl_valid, 0);
        check("idle_word", word_now(), W_ZERO);
        check("idle_ill", bus.illegal_op, 0);

        send(4'h3, 1'b0);
        check("ill3", {bus.ctrl_valid, bus.illegal_op}, 2'b11);
        check("ill3_word", word_now(), W_ZERO);

        // mult/div: opcode held valid throughout the busy window
        bus.instr_valid = 1'b1;
        bus.opcode      = 4'hF;
        bus.multi_div   = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("md_ready_%0d", i), bus.instr_ready, 0);
            check($sformatf("md_stall_%0d", i), bus.stall, 1);
            check($sformatf("md_valid_%0d", i), bus.ctrl_valid, (i == 4) ? 1 : 0);
            if (i == 4) check("md_word", word_now(), W_TA_MD);
            tick();
        end
        check("md_done_ready", bus.instr_ready, 1);
        check("md_done_valid", bus.ctrl_valid, 0);
        bus.instr_valid = 1'b0;
        bus.multi_div   = 1'b0;
        tick();
        check("md_no_reaccept", {bus.instr_ready, bus.ctrl_valid}, 2'b10);

        // BEQ then ADD back-to-back
        send(4'h6, 1'b0);
        check("beq_word", word_now(), W_BR);
        check("beq_bubble", {bus.ctrl_valid, bus.instr_ready, bus.stall}, 3'b101);
        bus.instr_valid = 1'b1;
        bus.opcode      = 4'hF;
        tick();
        check("add_wait", {bus.ctrl_valid, bus.instr_ready, bus.stall}, 3'b010);
        tick();
        bus.instr_valid = 1'b0;
        check("add_issue", bus.ctrl_valid, 1);
        check("add_word", word_now(), W_TA);

        send(4'h7, 1'b0);
        check("jmp_word", word_now(), W_JMP);
        check("jmp_stall", bus.stall, 1);
        send(4'h4, 1'b0);
        check("bgt_blocked", bus.ctrl_valid, 0);
        tick();

        // reset mid mult/div
        send(4'hF, 1'b1);
        tick();
        check("md2_busy", bus.instr_ready, 0);
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("mdrst_ready", bus.instr_ready, 1);
        check("mdrst_out", {bus.ctrl_valid, bus.stall, bus.halted, bus.illegal_op}, 0);
        check("mdrst_word", word_now(), W_ZERO);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("mdrst_quiet_%0d", i), bus.ctrl_valid, 0);
        end

        // HALT
        send(4'h0, 1'b0);
        check("halt_valid", bus.ctrl_valid, 1);
        check("halt_word", word_now(), W_ZERO);
        check("halt_flags", {bus.halted, bus.instr_ready, bus.stall, bus.illegal_op}, 4'b1000);
        bus.instr_valid = 1'b1;
        bus.opcode      = 4'hC;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("halt_hold_%0d", i),
                  {bus.halted, bus.instr_ready, bus.ctrl_valid}, 3'b100);
        end
        bus.instr_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("halt_rst", {bus.halted, bus.instr_ready, bus.ctrl_valid}, 3'b010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
